// File: rtl/weight_fetch_pkg.sv
// -----------------------------------------------------------------------------
// weight_fetch_pkg
//   Shared definitions for the weight fetch path: the controller state
//   encoding and the default geometry that weight_rom, the systolic array top
//   and weight_fetch_ctrl must agree on.
// -----------------------------------------------------------------------------
package weight_fetch_pkg;

    // Width of kernel_num / kernel_element / addr_r / rom_select.
    localparam int WF_CNT_DW      = 16;
    // Width of the absolute fold offset into weight_rom.
    localparam int WF_ABS_ADDR_DW = 16;
    // Array columns = ROMs read in parallel per fold.
    localparam int WF_COLS        = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_INIT = 2'd1,
        LOAD      = 2'd2,
        HOLD      = 2'd3
    } wf_state_e;

endpackage

// File: rtl/wf_elem_cnt.sv
// -----------------------------------------------------------------------------
// wf_elem_cnt
//   Stall-qualified element counter. Counts issued elements 0..last and wraps
//   back to 0 on the element that hits the terminal count, so the next fold
//   starts from 0 without an extra clear cycle.
//
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (held while the owner is idle)
//   en         : an element issues this cycle (already stall-qualified)
//   last       : terminal count value (elements - 1)
//   cnt        : index of the element presented this cycle
//   tc         : en && cnt == last -- the final element of the run issues now
// -----------------------------------------------------------------------------
module wf_elem_cnt
    import weight_fetch_pkg::*;
#(
    parameter int DW = WF_CNT_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    input  logic [DW-1:0] last,
    output logic [DW-1:0] cnt,
    output logic          tc
);

    logic at_last;

    assign at_last = (cnt == last);
    assign tc      = en && at_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (at_last) cnt <= '0;
            else         cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/weight_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// weight_fetch_ctrl
//   Sequencer in front of weight_rom. For every column fold it streams
//   kernel_element rows (addr_r 0..ke-1) with rom_select = first kernel of the
//   fold and base_addr = fold offset, then waits in HOLD for the array to
//   acknowledge the fold before moving on. Finishes once rom_select covers
//   kernel_num.
//
//   Inputs : clk, rst_n (async low), start, kernel_num, kernel_element,
//            mem_sig (ROM init done), stall, fold_ack
//   Outputs: addr_r, base_addr, rom_select, data_out_valid (ROM read enable,
//            combinational), w_valid_d1 / w_row_d1 (aligned with ROM data),
//            fold_loaded (pulse), busy, done (pulse)
// -----------------------------------------------------------------------------
module weight_fetch_ctrl
    import weight_fetch_pkg::*;
#(
    parameter int COLS        = WF_COLS,
    parameter int ABS_ADDR_DW = WF_ABS_ADDR_DW,
    parameter int CNT_DW      = WF_CNT_DW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CNT_DW-1:0]      kernel_num,
    input  logic [CNT_DW-1:0]      kernel_element,
    input  logic                   mem_sig,
    input  logic                   stall,
    input  logic                   fold_ack,
    output logic [CNT_DW-1:0]      addr_r,
    output logic [ABS_ADDR_DW-1:0] base_addr,
    output logic [CNT_DW-1:0]      rom_select,
    output logic                   data_out_valid,
    output logic                   w_valid_d1,
    output logic [CNT_DW-1:0]      w_row_d1,
    output logic                   fold_loaded,
    output logic                   busy,
    output logic                   done
);

    // One extra bit so rom_select + COLS cannot wrap past kernel_num.
    localparam logic [CNT_DW:0] COLS_W = (CNT_DW+1)'(COLS);

    wf_state_e         state;
    logic [CNT_DW-1:0] kn_q;
    logic [CNT_DW-1:0] ke_q;
    logic [CNT_DW-1:0] ke_last_q;
    logic [CNT_DW-1:0] cnt;
    logic              row_last;
    logic [CNT_DW:0]   next_rs;
    logic              last_fold;
    logic              empty_job;

    assign data_out_valid = (state == LOAD) && !stall;
    assign addr_r         = cnt;

    assign next_rs   = {1'b0, rom_select} + COLS_W;
    assign last_fold = (next_rs >= {1'b0, kn_q});
    assign empty_job = (kernel_num == '0) || (kernel_element == '0);

    wf_elem_cnt #(
        .DW (CNT_DW)
    ) u_elem_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == IDLE),
        .en    (data_out_valid),
        .last  (ke_last_q),
        .cnt   (cnt),
        .tc    (row_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            kn_q        <= '0;
            ke_q        <= '0;
            ke_last_q   <= '0;
            rom_select  <= '0;
            base_addr   <= '0;
            fold_loaded <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            fold_loaded <= 1'b0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (empty_job) begin
                            // Nothing to fetch: report completion straight away.
                            done <= 1'b1;
                        end else begin
                            kn_q       <= kernel_num;
                            ke_q       <= kernel_element;
                            ke_last_q  <= kernel_element - 1'b1;
                            rom_select <= '0;
                            base_addr  <= '0;
                            busy       <= 1'b1;
                            state      <= WAIT_INIT;
                        end
                    end
                end
                WAIT_INIT: begin
                    if (mem_sig) state <= LOAD;
                end
                LOAD: begin
                    // fold_ack is deliberately not looked at here; the array
                    // may only acknowledge a fold that is fully loaded.
                    if (row_last) begin
                        fold_loaded <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (fold_ack) begin
                        if (last_fold) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            // ROM is already initialised, go straight back to LOAD.
                            rom_select <= next_rs[CNT_DW-1:0];
                            base_addr  <= base_addr + ABS_ADDR_DW'(ke_q);
                            state      <= LOAD;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Copies matching the one-cycle registered read of weight_rom.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_valid_d1 <= 1'b0;
            w_row_d1   <= '0;
        end else begin
            w_valid_d1 <= data_out_valid;
            w_row_d1   <= addr_r;
        end
    end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_weight_fetch_ctrl
//   Directed bench for weight_fetch_ctrl (COLS=8). Inputs change on the falling
//   edge; outputs are sampled 1 ns later. Cycle k=0 is the cycle start is
//   driven; with mem_sig high the first LOAD cycle is k=2.
// -----------------------------------------------------------------------------
module tb_weight_fetch_ctrl;

    localparam int COLS        = 8;
    localparam int ABS_ADDR_DW = 16;
    localparam int CNT_DW      = 16;
    localparam int NK          = 512;
    localparam int OBS_W       = 3*CNT_DW + ABS_ADDR_DW + 5;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic [CNT_DW-1:0]      kernel_num = '0;
    logic [CNT_DW-1:0]      kernel_element = '0;
    logic                   mem_sig = 1'b0;
    logic                   stall = 1'b0;
    logic                   fold_ack = 1'b0;
    logic [CNT_DW-1:0]      addr_r;
    logic [ABS_ADDR_DW-1:0] base_addr;
    logic [CNT_DW-1:0]      rom_select;
    logic                   data_out_valid;
    logic                   w_valid_d1;
    logic [CNT_DW-1:0]      w_row_d1;
    logic                   fold_loaded;
    logic                   busy;
    logic                   done;

    weight_fetch_ctrl #(
        .COLS        (COLS),
        .ABS_ADDR_DW (ABS_ADDR_DW),
        .CNT_DW      (CNT_DW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .kernel_num     (kernel_num),
        .kernel_element (kernel_element),
        .mem_sig        (mem_sig),
        .stall          (stall),
        .fold_ack       (fold_ack),
        .addr_r         (addr_r),
        .base_addr      (base_addr),
        .rom_select     (rom_select),
        .data_out_valid (data_out_valid),
        .w_valid_d1     (w_valid_d1),
        .w_row_d1       (w_row_d1),
        .fold_loaded    (fold_loaded),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Per-cycle trace of one job, indexed by cycle k.
    logic                   cv    [NK];
    logic [CNT_DW-1:0]      ca    [NK];
    logic                   cwv   [NK];
    logic [CNT_DW-1:0]      cwr   [NK];
    logic [CNT_DW-1:0]      crs   [NK];
    logic [ABS_ADDR_DW-1:0] cba   [NK];
    logic                   cfl   [NK];
    int done_k, vcount, flcount, busy_gaps;
    logic [OBS_W-1:0] obs;

    // Runs one job. md: cycle mem_sig goes high; stall during [slo,shi];
    // during [jlo,jhi] a stray start (kernel_num=0) and fold_ack are driven;
    // each fold is acknowledged adly cycles after fold_loaded is seen.
    task automatic run_job(input logic [CNT_DW-1:0] kn, input logic [CNT_DW-1:0] ke,
                           input int md, input int slo, input int shi,
                           input int jlo, input int jhi, input int adly);
        int ack_at;
        for (int i = 0; i < NK; i++) begin
            cv[i] = 1'b0; ca[i] = '0; cwv[i] = 1'b0; cwr[i] = '0;
            crs[i] = '0; cba[i] = '0; cfl[i] = 1'b0;
        end
        done_k = -1; vcount = 0; flcount = 0; busy_gaps = 0; ack_at = -1;
        @(negedge clk);
        kernel_num = kn; kernel_element = ke; start = 1'b1;
        stall = 1'b0; fold_ack = 1'b0; mem_sig = (md <= 0);
        for (int k = 1; k < NK; k++) begin
            @(negedge clk);
            start = (k >= jlo && k <= jhi);
            if (start) kernel_num = '0;
            stall   = (k >= slo && k <= shi);
            mem_sig = (k >= md);
            #1;
            cv[k] = data_out_valid; ca[k] = addr_r; cwv[k] = w_valid_d1;
            cwr[k] = w_row_d1; crs[k] = rom_select; cba[k] = base_addr;
            cfl[k] = fold_loaded;
            if (data_out_valid) vcount++;
            if (fold_loaded) begin flcount++; ack_at = k + adly; end
            if (done) begin done_k = k; break; end
            if (!busy) busy_gaps++;
            fold_ack = (k == ack_at) || start;
        end
        start = 1'b0; stall = 1'b0; fold_ack = 1'b0; mem_sig = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        obs = {addr_r, base_addr, rom_select, w_row_d1, data_out_valid, w_valid_d1, fold_loaded, busy, done};
        tests_run++;
        if (obs !== '0) begin tests_failed++; $display("FAIL reset_held: outputs=%h expected all 0", obs); end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk); #1;
        obs = {addr_r, base_addr, rom_select, w_row_d1, data_out_valid, w_valid_d1, fold_loaded, busy, done};
        tests_run++;
        if (obs !== '0) begin tests_failed++; $display("FAIL reset_idle: outputs=%h expected all 0", obs); end
    endtask

    task automatic test_single_fold();
        run_job(16'd6, 16'd15, 0, -1, -1, -1, -1, 0);
        tests_run++;
        if (vcount !== 15) begin tests_failed++; $display("FAIL single_vcount: got %0d expected 15", vcount); end
        tests_run++;
        if (cv[1] !== 1'b0) begin tests_failed++; $display("FAIL single_wait_init_valid: got %b expected 0", cv[1]); end
        for (int r = 0; r < 15; r++) begin
            tests_run++;
            if (cv[2+r] !== 1'b1 || ca[2+r] !== CNT_DW'(r) || crs[2+r] !== '0 || cba[2+r] !== '0) begin
                tests_failed++;
                $display("FAIL single_row%0d: valid=%b addr=%0d rs=%0d base=%0d expected 1/%0d/0/0",
                         r, cv[2+r], ca[2+r], crs[2+r], cba[2+r], r);
            end
        end
        tests_run++;
        if (cwv[2] !== 1'b0 || cwv[17] !== 1'b1 || cwr[17] !== 16'd14) begin
            tests_failed++;
            $display("FAIL single_delayed: wv2=%b wv17=%b wr17=%0d expected 0/1/14", cwv[2], cwv[17], cwr[17]);
        end
        tests_run++;
        if (flcount !== 1 || cfl[17] !== 1'b1) begin
            tests_failed++; $display("FAIL single_fold_loaded: count=%0d at17=%b expected 1/1", flcount, cfl[17]);
        end
        tests_run++;
        if (done_k !== 18) begin tests_failed++; $display("FAIL single_done_cycle: got %0d expected 18", done_k); end
        tests_run++;
        if (busy !== 1'b0 || busy_gaps !== 0) begin
            tests_failed++; $display("FAIL single_busy: busy=%b gaps=%0d expected 0/0", busy, busy_gaps);
        end
    endtask

    task automatic test_multi_fold();
        run_job(16'd20, 16'd15, 0, -1, -1, -1, -1, 0);
        tests_run++;
        if (vcount !== 45) begin tests_failed++; $display("FAIL multi_vcount: got %0d expected 45", vcount); end
        tests_run++;
        if (flcount !== 3) begin tests_failed++; $display("FAIL multi_folds: got %0d expected 3", flcount); end
        tests_run++;
        if (done_k !== 50) begin tests_failed++; $display("FAIL multi_done_cycle: got %0d expected 50", done_k); end
        tests_run++;
        if (cv[17] !== 1'b0 || cv[33] !== 1'b0) begin
            tests_failed++; $display("FAIL multi_hold_valid: v17=%b v33=%b expected 0/0", cv[17], cv[33]);
        end
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < 15; r++) begin
                tests_run++;
                if (cv[2+16*f+r] !== 1'b1 || ca[2+16*f+r] !== CNT_DW'(r) ||
                    crs[2+16*f+r] !== CNT_DW'(8*f) || cba[2+16*f+r] !== ABS_ADDR_DW'(15*f)) begin
                    tests_failed++;
                    $display("FAIL multi_f%0d_row%0d: valid=%b addr=%0d rs=%0d base=%0d expected 1/%0d/%0d/%0d",
                             f, r, cv[2+16*f+r], ca[2+16*f+r], crs[2+16*f+r], cba[2+16*f+r], r, 8*f, 15*f);
                end
            end
        end
    endtask

    task automatic test_stall();
        int v0;
        run_job(16'd20, 16'd15, 0, 5, 7, -1, -1, 0);
        v0 = 0;
        for (int k = 2; k <= 20; k++) if (cv[k]) v0++;
        tests_run++;
        if (v0 !== 15) begin tests_failed++; $display("FAIL stall_fold0_vcount: got %0d expected 15", v0); end
        for (int k = 5; k <= 7; k++) begin
            tests_run++;
            if (cv[k] !== 1'b0 || ca[k] !== 16'd3) begin
                tests_failed++; $display("FAIL stall_hold_k%0d: valid=%b addr=%0d expected 0/3", k, cv[k], ca[k]);
            end
        end
        tests_run++;
        if (cv[8] !== 1'b1 || ca[8] !== 16'd3) begin
            tests_failed++; $display("FAIL stall_resume: valid=%b addr=%0d expected 1/3", cv[8], ca[8]);
        end
        tests_run++;
        if (cwv[5] !== 1'b1 || cwv[6] !== 1'b0 || cwv[7] !== 1'b0 || cwv[8] !== 1'b0 ||
            cwv[9] !== 1'b1 || cwr[9] !== 16'd3) begin
            tests_failed++;
            $display("FAIL stall_delayed_gap: wv5..9=%b%b%b%b%b wr9=%0d expected 10001/3",
                     cwv[5], cwv[6], cwv[7], cwv[8], cwv[9], cwr[9]);
        end
        tests_run++;
        if (vcount !== 45 || done_k !== 53) begin
            tests_failed++; $display("FAIL stall_total: vcount=%0d done=%0d expected 45/53", vcount, done_k);
        end
    endtask

    task automatic test_mem_wait();
        int vpre;
        run_job(16'd6, 16'd15, 10, -1, -1, -1, -1, 0);
        vpre = 0;
        for (int k = 1; k <= 10; k++) if (cv[k]) vpre++;
        tests_run++;
        if (vpre !== 0) begin tests_failed++; $display("FAIL memwait_early_valid: got %0d expected 0", vpre); end
        tests_run++;
        if (cv[11] !== 1'b1 || ca[11] !== 16'd0) begin
            tests_failed++; $display("FAIL memwait_first_valid: valid=%b addr=%0d expected 1/0", cv[11], ca[11]);
        end
        tests_run++;
        if (busy_gaps !== 0) begin tests_failed++; $display("FAIL memwait_busy: gaps=%0d expected 0", busy_gaps); end
        tests_run++;
        if (done_k !== 27 || vcount !== 15) begin
            tests_failed++; $display("FAIL memwait_done: done=%0d vcount=%0d expected 27/15", done_k, vcount);
        end
    endtask

    task automatic test_zero_job();
        run_job(16'd0, 16'd15, 0, -1, -1, -1, -1, 0);
        tests_run++;
        if (done_k !== 1 || vcount !== 0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL zero_kn: done=%0d vcount=%0d busy=%b expected 1/0/0", done_k, vcount, busy);
        end
        run_job(16'd5, 16'd0, 0, -1, -1, -1, -1, 0);
        tests_run++;
        if (done_k !== 1 || vcount !== 0 || busy !== 1'b0) begin
            tests_failed++; $display("FAIL zero_ke: done=%0d vcount=%0d busy=%b expected 1/0/0", done_k, vcount, busy);
        end
    endtask

    task automatic test_ignored();
        // Stray start/fold_ack at k=3..5 (inside LOAD, incl. the last-row cycle);
        // the real ack comes 3 cycles into HOLD.
        run_job(16'd6, 16'd4, 0, -1, -1, 3, 5, 3);
        for (int r = 0; r < 4; r++) begin
            tests_run++;
            if (cv[2+r] !== 1'b1 || ca[2+r] !== CNT_DW'(r)) begin
                tests_failed++; $display("FAIL ignored_row%0d: valid=%b addr=%0d expected 1/%0d", r, cv[2+r], ca[2+r], r);
            end
        end
        tests_run++;
        if (vcount !== 4 || flcount !== 1 || cfl[6] !== 1'b1) begin
            tests_failed++;
            $display("FAIL ignored_fold: vcount=%0d folds=%0d fl6=%b expected 4/1/1", vcount, flcount, cfl[6]);
        end
        tests_run++;
        if (done_k !== 10 || busy_gaps !== 0) begin
            tests_failed++; $display("FAIL ignored_done: done=%0d gaps=%0d expected 10/0", done_k, busy_gaps);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        kernel_num = 16'd20; kernel_element = 16'd15; mem_sig = 1'b1; start = 1'b1;
        @(negedge clk) start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk); #1;
            if (fold_loaded) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL rstmid_fold0: fold_loaded=0 expected 1 within 60 cycles"); end
        fold_ack = 1'b1;
        @(negedge clk) fold_ack = 1'b0;
        #1;
        tests_run++;
        if (data_out_valid !== 1'b1 || rom_select !== 16'd8 || base_addr !== 16'd15 || addr_r !== 16'd0) begin
            tests_failed++;
            $display("FAIL rstmid_fold1: valid=%b rs=%0d base=%0d addr=%0d expected 1/8/15/0",
                     data_out_valid, rom_select, base_addr, addr_r);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        obs = {addr_r, base_addr, rom_select, w_row_d1, data_out_valid, w_valid_d1, fold_loaded, busy, done};
        tests_run++;
        if (obs !== '0) begin tests_failed++; $display("FAIL rstmid_async: outputs=%h expected all 0", obs); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            tests_run++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                tests_failed++; $display("FAIL rstmid_no_done%0d: done=%b busy=%b expected 0/0", i, done, busy);
            end
        end
        @(negedge clk) rst_n = 1'b1;
        run_job(16'd6, 16'd15, 0, -1, -1, -1, -1, 0);
        tests_run++;
        if (cv[2] !== 1'b1 || ca[2] !== 16'd0 || crs[2] !== 16'd0 || cba[2] !== 16'd0 || done_k !== 18) begin
            tests_failed++;
            $display("FAIL rstmid_restart: valid=%b addr=%0d rs=%0d base=%0d done=%0d expected 1/0/0/0/18",
                     cv[2], ca[2], crs[2], cba[2], done_k);
        end
    endtask

    initial begin
        test_reset();
        test_single_fold();
        test_multi_fold();
        test_stall();
        test_mem_wait();
        test_zero_job();
        test_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule
